fp_mul_pipe: RTL and testbench

Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with valid/ready handshaking. It is the next-generation multiplier for the floating-point calculator. It accepts one operand pair per cycle and returns a round-to-nearest-even product. It adds proper special-value handling (±Inf, NaN, overflow, underflow) and backpressure so it can sit directly in DNN MAC datapaths.

---
 rtl/fp_mul_pipe.sv | 175 +++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
// Subnormals flush to zero on input and output; rounding is round-to-nearest-even.
module fp_mul_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1+EXP_W+FRAC_W-1:0]   a,
  input  logic [1+EXP_W+FRAC_W-1:0]   b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1+EXP_W+FRAC_W-1:0]   result,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        invalid
);

  localparam int unsigned W    = 1 + EXP_W + FRAC_W;
  localparam int unsigned MW   = FRAC_W + 1;
  localparam int unsigned PW   = 2 * MW;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [EW-1:0] EXP_SAT  = EW'((1 << EXP_W) - 1);

  // A stalled output freezes every stage, bubbles included
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [FRAC_W-1:0] a_frac, b_frac;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  assign a_exp  = a[W-2 -: EXP_W];
  assign b_exp  = b[W-2 -: EXP_W];
  assign a_frac = a[FRAC_W-1:0];
  assign b_frac = b[FRAC_W-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
  assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);

  // Stage 1: operand capture and pairwise classification
  logic              s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
  logic [EXP_W-1:0]  s1_ea, s1_eb;
  logic [FRAC_W-1:0] s1_fa, s1_fb;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_ea    <= '0;
      s1_eb    <= '0;
      s1_fa    <= '0;
      s1_fb    <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_sign  <= a[W-1] ^ b[W-1];
      s1_nan   <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      s1_inf   <= a_inf | b_inf;
      s1_zero  <= a_zero | b_zero;
      s1_ea    <= a_exp;
      s1_eb    <= b_exp;
      s1_fa    <= a_frac;
      s1_fb    <= b_frac;
    end
  end

  // Stage 2 combinational: special-value result selection
  logic         spec, spec_inv;
  logic [W-1:0] spec_res;

  always_comb begin
    spec     = 1'b1;
    spec_inv = 1'b0;
    spec_res = '0;
    if (s1_nan) begin
      spec_inv = 1'b1;
      spec_res = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
    end else if (s1_inf) begin
      spec_res = {s1_sign, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (s1_zero) begin
      spec_res = {s1_sign, {(W-1){1'b0}}};
    end else begin
      spec = 1'b0;
    end
  end

  // Stage 2: mantissa product and biased exponent sum
  logic                 s2_valid, s2_sign, s2_spec, s2_spec_inv;
  logic [W-1:0]         s2_spec_res;
  logic [PW-1:0]        s2_prod;
  logic signed [EW-1:0] s2_exp;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_spec     <= 1'b0;
      s2_spec_inv <= 1'b0;
      s2_spec_res <= '0;
      s2_prod     <= '0;
      s2_exp      <= '0;
    end else if (!stall) begin
      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_spec     <= spec;
      s2_spec_inv <= spec_inv;
      s2_spec_res <= spec_res;
      s2_prod     <= PW'({1'b1, s1_fa}) * PW'({1'b1, s1_fb});
      s2_exp      <= EW'(s1_ea) + EW'(s1_eb) - EW'(BIAS);
    end
  end

  // Stage 3 combinational: normalise, round to nearest even, saturate, pack
  logic                 norm, guard_bit, sticky, round_up, carry;
  logic [PW-1:0]        prod_n;
  logic [FRAC_W-1:0]    frac_r;
  logic signed [EW-1:0] exp_r;
  logic [W-1:0]         nxt_result;
  logic                 nxt_ovf, nxt_unf, nxt_inv;

  always_comb begin
    norm       = s2_prod[PW-1];
    prod_n     = norm ? s2_prod : (s2_prod << 1);
    guard_bit  = prod_n[FRAC_W];
    sticky     = |prod_n[FRAC_W-1:0];
    round_up   = guard_bit & (sticky | prod_n[FRAC_W+1]);
    // Rounding carries out only when the kept mantissa is all ones
    carry      = round_up & (&prod_n[PW-1 -: MW]);
    frac_r     = prod_n[PW-2 -: FRAC_W] + FRAC_W'(round_up);
    exp_r      = s2_exp + EW'(norm) + EW'(carry);
    nxt_ovf    = 1'b0;
    nxt_unf    = 1'b0;
    nxt_inv    = 1'b0;
    nxt_result = {s2_sign, exp_r[EXP_W-1:0], frac_r};
    if (s2_spec) begin
      nxt_result = s2_spec_res;
      nxt_inv    = s2_spec_inv;
    end else if (exp_r >= EXP_SAT) begin
      nxt_result = {s2_sign, EXP_ONES, {FRAC_W{1'b0}}};
      nxt_ovf    = 1'b1;
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      nxt_result = {s2_sign, {(W-1){1'b0}}};
      nxt_unf    = 1'b1;
    end
  end

  // Stage 3: output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      result    <= nxt_result;
      overflow  <= nxt_ovf;
      underflow <= nxt_unf;
      invalid   <= nxt_inv;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (binary32 configuration): directed
// vectors, backpressure, mid-flight reset and randomised traffic.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        overflow, underflow, invalid;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [34:0] sb_q[$];
  logic        rnd_done;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  // Reference product as {result, overflow, underflow, invalid}
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
    int          ex, ey, e, sh;
    logic [22:0] fx, fy;
    logic        s, zx, zy, ix, iy, nx, ny;
    longint      p, q, r, half;
    ex = int'(x[30:23]);  ey = int'(y[30:23]);
    fx = x[22:0];         fy = y[22:0];
    zx = (ex == 0);       zy = (ey == 0);
    ix = (ex == 255) && (fx == 0);  iy = (ey == 255) && (fy == 0);
    nx = (ex == 255) && (fx != 0);  ny = (ey == 255) && (fy != 0);
    if (nx || ny || (ix && zy) || (iy && zx)) return {32'h7FC00000, 3'b001};
    s = x[31] ^ y[31];
    if (ix || iy) return {s, 8'hFF, 23'h0, 3'b000};
    if (zx || zy) return {s, 31'h0, 3'b000};
    p = longint'({1'b1, fx}) * longint'({1'b1, fy});
    e = ex + ey - 127;
    if ((p >> 47) != 0) begin sh = 24; e = e + 1; end
    else sh = 23;
    q    = p >> sh;
    r    = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q == (longint'(1) << 24)) begin q = longint'(1) << 23; e = e + 1; end
    if (e >= 255) return {s, 8'hFF, 23'h0, 3'b100};
    if (e <= 0)   return {s, 31'h0, 3'b010};
    return {s, 8'(e), q[22:0], 3'b000};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0:       e = 8'h00;
      1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
      2:       e = 8'($urandom_range(190, 254));
      3:       e = 8'($urandom_range(1, 60));
      4:       begin e = 8'($urandom_range(100, 154)); f = '1; end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard consumer plus hold-while-stalled checker
  initial begin
    logic        prev_stall;
    logic [34:0] prev_out, got, exp_v;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      got = {result, overflow, underflow, invalid};
      if (reset_n !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (out_valid !== 1'b1 || got !== prev_out) begin
            errors++;
            $display("FAIL hold: got v=%b %h, required v=1 %h", out_valid, got, prev_out);
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %h, required no output", got);
          end else begin
            exp_v = sb_q.pop_front();
            if (got !== exp_v) begin
              errors++;
              $display("FAIL scoreboard: got res=%h flags=%b, required res=%h flags=%b",
                       got[34:3], got[2:0], exp_v[34:3], exp_v[2:0]);
            end
          end
        end
        prev_stall = out_valid & ~out_ready;
        prev_out   = got;
      end
    end
  end

  // Drive one operand pair; called and returns just after a rising edge
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb, output int acc_cyc);
    int n;
    in_valid = 1'b1; a = xa; b = xb; n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got in_ready=%b, required 1", in_ready);
    end else begin
      sb_q.push_back(model(xa, xb));
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_wait(input logic [31:0] xa, input logic [31:0] xb,
                            output logic [34:0] got, output int lat);
    int acc, n;
    issue(xa, xb, acc);
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    lat = (n >= 20) ? -1 : cyc - acc;
    got = {result, overflow, underflow, invalid};
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h, required 0", result); end
    checks++;
    if ({overflow, underflow, invalid} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b, required 000", {overflow, underflow, invalid});
    end
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [34:0] got;
    int lat;
    issue_wait(32'h3FC00000, 32'h40000000, got, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d, required 3", lat); end
    checks++;
    if (got !== {32'h40400000, 3'b000}) begin
      errors++; $display("FAIL basic_result: got %h/%b, required 40400000/000", got[34:3], got[2:0]);
    end
  endtask

  task automatic test_rne();
    logic [34:0] got;
    int lat;
    issue_wait(32'h3F800001, 32'h3FC00000, got, lat);
    checks++;
    if (got !== {32'h3FC00002, 3'b000}) begin
      errors++; $display("FAIL rne_tie_up: got %h/%b, required 3FC00002/000", got[34:3], got[2:0]);
    end
    issue_wait(32'h3F800001, 32'h3F800001, got, lat);
    checks++;
    if (got !== {32'h3F800002, 3'b000}) begin
      errors++; $display("FAIL rne_below_half: got %h/%b, required 3F800002/000", got[34:3], got[2:0]);
    end
    issue_wait(32'h3FFFFFFF, 32'h3FFFFFFF, got, lat);
    checks++;
    if (got !== {32'h407FFFFE, 3'b000}) begin
      errors++; $display("FAIL rne_norm: got %h/%b, required 407FFFFE/000", got[34:3], got[2:0]);
    end
  endtask

  task automatic test_ovf_unf();
    logic [34:0] got;
    int lat;
    issue_wait(32'h7F000000, 32'h7F000000, got, lat);
    checks++;
    if (got !== {32'h7F800000, 3'b100}) begin
      errors++; $display("FAIL overflow: got %h/%b, required 7F800000/100", got[34:3], got[2:0]);
    end
    issue_wait(32'h00800000, 32'h00800000, got, lat);
    checks++;
    if (got !== {32'h00000000, 3'b010}) begin
      errors++; $display("FAIL underflow: got %h/%b, required 00000000/010", got[34:3], got[2:0]);
    end
    issue_wait(32'hBF800000, 32'h00000001, got, lat);
    checks++;
    if (got !== {32'h80000000, 3'b000}) begin
      errors++; $display("FAIL subnormal_ftz: got %h/%b, required 80000000/000", got[34:3], got[2:0]);
    end
  endtask

  task automatic test_specials();
    logic [34:0] got;
    int lat;
    issue_wait(32'h7FC00001, 32'h3F800000, got, lat);
    checks++;
    if (got !== {32'h7FC00000, 3'b001}) begin
      errors++; $display("FAIL nan_input: got %h/%b, required 7FC00000/001", got[34:3], got[2:0]);
    end
    issue_wait(32'h7F800000, 32'h80000000, got, lat);
    checks++;
    if (got !== {32'h7FC00000, 3'b001}) begin
      errors++; $display("FAIL inf_times_zero: got %h/%b, required 7FC00000/001", got[34:3], got[2:0]);
    end
    issue_wait(32'hFF800000, 32'h40000000, got, lat);
    checks++;
    if (got !== {32'hFF800000, 3'b000}) begin
      errors++; $display("FAIL neg_inf: got %h/%b, required FF800000/000", got[34:3], got[2:0]);
    end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        int acc;
        for (int i = 0; i < 5; i++) issue(32'h3F800000 + (i << 21), 32'h40400000, acc);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_in_ready: got in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_output: got %b, required 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    logic [34:0] got;
    int acc, lat, stale;
    issue(32'h40000000, 32'h40000000, acc);
    issue(32'h40400000, 32'h40000000, acc);
    in_valid = 1'b1; a = 32'h40800000; b = 32'h40000000;
    reset_n = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL reset_stale: got %0d valid cycles, required 0", stale); end
    @(posedge clk); #1;
    issue_wait(32'h40A00000, 32'h3F000000, got, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL post_reset_latency: got %0d, required 3", lat); end
    checks++;
    if (got !== {32'h40200000, 3'b000}) begin
      errors++; $display("FAIL post_reset_result: got %h/%b, required 40200000/000", got[34:3], got[2:0]);
    end
  endtask

  task automatic test_random();
    rnd_done = 1'b0;
    fork
      begin
        int acc;
        for (int i = 0; i < 60; i++) issue(rand_op(), rand_op(), acc);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; rnd_done = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_rne();
    test_ovf_unf();
    test_specials();
    drain();
    test_back_to_back();
    test_reset_midflight();
    drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
